ecp5_pll_manager: RTL and testbench
===================================

// Module: ecp5_pll_manager
// PURPOSE
//  Controller side of the ECP5 EHXPLLL primitive. Drives PLL RST, qualifies LOCK, and releases a
//  downstream reset only after lock has been stable. Issues dynamic phase steps
//  (PHASESEL/PHASEDIR/PHASESTEP) on request, and recovers automatically from lock loss or lock timeout.
//  Runs on a free-running reference clock, never on a PLL output.
// PARAMETERS
//  RST_CYCLES    16     cycles pll_rst is held high per reset pulse (>=1)
//  LOCK_STABLE   1024   cycles synced lock must stay high before release (>=1)
//  LOCK_TIMEOUT  65536  cycles allowed in WAIT_LOCK before re-pulsing RST
//  SETUP_CYCLES  2      cycles PHASESEL/PHASEDIR are stable before the first PHASESTEP
//  STEP_PULSE    4      PHASESTEP high time, in cycles
//  STEP_GAP      4      PHASESTEP low time between steps, in cycles
//  STEP_W        8      width of the step-count field
// PORTS
//  clk              in   1       reference clock
//  reset_n          in   1       asynchronous, active-low reset
//  pll_lock         in   1       PLL LOCK, asynchronous to clk
//  pll_rst          out  1       to PLL RST
//  pll_phasesel     out  2       to PHASESEL1:0 (00 CLKOS, 01 CLKOS2, 10 CLKOS3, 11 CLKOP)
//  pll_phasedir     out  1       to PHASEDIR
//  pll_phasestep    out  1       to PHASESTEP, active-high pulse
//  pll_phaseloadreg out  1       to PHASELOADREG, constant 0
//  pll_stdby        out  1       to STDBY, constant 0
//  sys_reset_n      out  1       downstream reset, active-low
//  locked           out  1       high in RUN and PH_* states
//  relock_count     out  8       count of recoveries, saturates at 255
//  ph_valid         in   1       phase request valid
//  ph_ready         out  1       request accepted when ph_valid & ph_ready
//  ph_sel           in   2       target output, same encoding as pll_phasesel
//  ph_dir           in   1       step direction
//  ph_steps         in   STEP_W  number of steps
//  ph_done          out  1       1-cycle pulse when a request completes
//  ph_abort         out  1       1-cycle pulse when a request is killed by lock loss
// BEHAVIOUR
//  Reset values:
//   - pll_rst=1, sys_reset_n=0; all other outputs 0; state RESET_PLL; timer 0.
//  Lock synchronisation:
//   - pll_lock passes through a 2-FF synchroniser to give lock_s (2-cycle latency).
//  Outputs:
//   - All outputs are registered, except ph_ready, which equals (state==RUN).
//  Single timer; it clears on every state change.
//  States and transitions:
//   - RESET_PLL: pll_rst=1. After RST_CYCLES cycles -> WAIT_LOCK.
//   - WAIT_LOCK: if lock_s -> STABLE.
//     Otherwise, when timer reaches LOCK_TIMEOUT-1 -> RESET_PLL and relock_count++.
//   - STABLE: if !lock_s -> WAIT_LOCK.
//     When timer reaches LOCK_STABLE-1 -> RUN; sys_reset_n and locked go 1 on entry.
//   - RUN: on accept, latch sel/dir/steps.
//     If ph_steps==0, ph_done pulses the next cycle and the state stays RUN.
//     Otherwise, drive pll_phasesel/pll_phasedir from the latched values -> PH_SETUP.
//   - PH_SETUP: after SETUP_CYCLES -> PH_PULSE.
//   - PH_PULSE: pll_phasestep=1 for STEP_PULSE cycles.
//     On exit, decrement the remaining count -> PH_GAP.
//   - PH_GAP: pll_phasestep=0 for STEP_GAP cycles.
//     Then, if remaining==0 -> RUN with a ph_done pulse; else -> PH_PULSE.
//  Lock loss: !lock_s in RUN or any PH_* state -> RESET_PLL.
//   - On the next edge: sys_reset_n=0, locked=0, pll_phasestep=0, relock_count++.
//   - If a request was in flight, ph_abort pulses; ph_done does not pulse for that request.
//   - A lock drop exactly as RUN is entered takes effect on the next edge; no glitch-free guarantee beyond that.
//  pll_phasesel/pll_phasedir hold their last values after completion or abort.
//  One request is in flight at a time; no queueing.
//  Phase position is cumulative in the PLL; this block keeps no phase-position record.
//  reset_n asserted mid-operation: all outputs go to reset values immediately.
//   - pll_phasestep may truncate; this is accepted.
// STRUCTURE
//  Package ecp5_pll_pkg:
//   - state enum {RESET_PLL, WAIT_LOCK, STABLE, RUN, PH_SETUP, PH_PULSE, PH_GAP}
//   - PHASESEL_CLKOS/CLKOS2/CLKOS3/CLKOP constants
//   - timer width = clog2 of the largest parameter
//  Sub-module: cdc_sync_bit (2-FF synchroniser, reset to 0) for pll_lock.
// TESTING  (RST_CYCLES=4 LOCK_STABLE=8 LOCK_TIMEOUT=32 SETUP=2 PULSE=2 GAP=2)
//  1. Release reset_n, raise pll_lock 10 cycles after pll_rst falls:
//     pll_rst high exactly 4 cycles; sys_reset_n rises 2+8 cycles after the lock edge; relock_count=0.
//  2. Hold pll_lock=0: pll_rst re-pulses every 4+32 cycles; relock_count increments each time and stops at 255.
//  3. In RUN, request sel=11 dir=1 steps=3:
//     phasesel=11 and phasedir=1 for 2 cycles before the first step;
//     3 PHASESTEP pulses of 2 high / 2 low; ph_done 1 cycle after the last gap; ph_ready low throughout.
//  4. In RUN, request steps=0: no PHASESTEP activity, ph_done pulses next cycle, ph_ready stays 1.
//  5. Drop pll_lock during the 2nd PH_PULSE:
//     phasestep=0, sys_reset_n=0, ph_abort=1 within 3 cycles; no ph_done; relock_count+1; full relock sequence follows.
//  6. Toggle lock low for 3 cycles during STABLE: returns to WAIT_LOCK; the stable timer restarts from 0.

Source files
------------

// File: rtl/ecp5_pll_pkg.sv
// Shared types and helpers for the ECP5 EHXPLLL controller.
package ecp5_pll_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    PH_SETUP,
    PH_PULSE,
    PH_GAP
  } state_t;

  localparam logic [1:0] PHASESEL_CLKOS  = 2'b00;
  localparam logic [1:0] PHASESEL_CLKOS2 = 2'b01;
  localparam logic [1:0] PHASESEL_CLKOS3 = 2'b10;
  localparam logic [1:0] PHASESEL_CLKOP  = 2'b11;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Width able to hold every terminal count (value-1) of the shared timer.
  function automatic int unsigned timer_width(input int unsigned largest);
    return (largest < 2) ? 1 : $clog2(largest);
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Two-flop synchroniser for a single level signal, reset to 0.
module cdc_sync_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ecp5_pll_manager.sv
// EHXPLLL controller: PLL reset/lock qualification, downstream reset release,
// dynamic phase stepping and automatic recovery from lock loss or timeout.
module ecp5_pll_manager
  import ecp5_pll_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned STEP_PULSE   = 4,
  parameter int unsigned STEP_GAP     = 4,
  parameter int unsigned STEP_W       = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pll_lock,
  output logic              pll_rst,
  output logic [1:0]        pll_phasesel,
  output logic              pll_phasedir,
  output logic              pll_phasestep,
  output logic              pll_phaseloadreg,
  output logic              pll_stdby,
  output logic              sys_reset_n,
  output logic              locked,
  output logic [7:0]        relock_count,
  input  logic              ph_valid,
  output logic              ph_ready,
  input  logic [1:0]        ph_sel,
  input  logic              ph_dir,
  input  logic [STEP_W-1:0] ph_steps,
  output logic              ph_done,
  output logic              ph_abort
);

  localparam int unsigned TIMER_W = timer_width(
    max2(max2(max2(RST_CYCLES, LOCK_STABLE), max2(LOCK_TIMEOUT, SETUP_CYCLES)),
         max2(STEP_PULSE, STEP_GAP)));

  localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(LOCK_STABLE - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] SETUP_LAST   = TIMER_W'(SETUP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] PULSE_LAST   = TIMER_W'(STEP_PULSE - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST     = TIMER_W'(STEP_GAP - 1);

  logic lock_s;

  cdc_sync_bit u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [STEP_W-1:0]  remaining_q, remaining_d;
  logic               pll_rst_q, pll_rst_d;
  logic [1:0]         phasesel_q, phasesel_d;
  logic               phasedir_q, phasedir_d;
  logic               phasestep_q, phasestep_d;
  logic               sys_reset_n_q, sys_reset_n_d;
  logic               locked_q, locked_d;
  logic [7:0]         relock_count_q, relock_count_d;
  logic               ph_done_q, ph_done_d;
  logic               ph_abort_q, ph_abort_d;
  logic               relock;

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q + TIMER_W'(1);
    remaining_d    = remaining_q;
    pll_rst_d      = pll_rst_q;
    phasesel_d     = phasesel_q;
    phasedir_d     = phasedir_q;
    phasestep_d    = phasestep_q;
    sys_reset_n_d  = sys_reset_n_q;
    locked_d       = locked_q;
    relock_count_d = relock_count_q;
    ph_done_d      = 1'b0;
    ph_abort_d     = 1'b0;
    relock         = 1'b0;

    case (state_q)
      RESET_PLL: begin
        if (timer_q == RST_LAST) begin
          state_d   = WAIT_LOCK;
          pll_rst_d = 1'b0;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) state_d = STABLE;
        else if (timer_q == TIMEOUT_LAST) relock = 1'b1;
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (timer_q == STABLE_LAST) begin
          state_d       = RUN;
          sys_reset_n_d = 1'b1;
          locked_d      = 1'b1;
        end
      end
      RUN: begin
        // ph_ready is high here, so a request presented as lock drops counts as accepted and aborted.
        if (!lock_s) begin
          relock     = 1'b1;
          ph_abort_d = ph_valid;
        end else if (ph_valid) begin
          if (ph_steps == '0) begin
            ph_done_d = 1'b1;
          end else begin
            phasesel_d  = ph_sel;
            phasedir_d  = ph_dir;
            remaining_d = ph_steps;
            state_d     = PH_SETUP;
          end
        end
      end
      PH_SETUP: begin
        if (!lock_s) begin
          relock     = 1'b1;
          ph_abort_d = 1'b1;
        end else if (timer_q == SETUP_LAST) begin
          state_d     = PH_PULSE;
          phasestep_d = 1'b1;
        end
      end
      PH_PULSE: begin
        if (!lock_s) begin
          relock     = 1'b1;
          ph_abort_d = 1'b1;
        end else if (timer_q == PULSE_LAST) begin
          state_d     = PH_GAP;
          phasestep_d = 1'b0;
          remaining_d = remaining_q - STEP_W'(1);
        end
      end
      PH_GAP: begin
        if (!lock_s) begin
          relock     = 1'b1;
          ph_abort_d = 1'b1;
        end else if (timer_q == GAP_LAST) begin
          if (remaining_q == '0) begin
            state_d   = RUN;
            ph_done_d = 1'b1;
          end else begin
            state_d     = PH_PULSE;
            phasestep_d = 1'b1;
          end
        end
      end
      default: relock = 1'b1;
    endcase

    if (relock) begin
      state_d       = RESET_PLL;
      pll_rst_d     = 1'b1;
      sys_reset_n_d = 1'b0;
      locked_d      = 1'b0;
      phasestep_d   = 1'b0;
      if (relock_count_q != '1) relock_count_d = relock_count_q + 8'd1;
    end

    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= RESET_PLL;
      timer_q        <= '0;
      remaining_q    <= '0;
      pll_rst_q      <= 1'b1;
      phasesel_q     <= PHASESEL_CLKOS;
      phasedir_q     <= 1'b0;
      phasestep_q    <= 1'b0;
      sys_reset_n_q  <= 1'b0;
      locked_q       <= 1'b0;
      relock_count_q <= '0;
      ph_done_q      <= 1'b0;
      ph_abort_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      remaining_q    <= remaining_d;
      pll_rst_q      <= pll_rst_d;
      phasesel_q     <= phasesel_d;
      phasedir_q     <= phasedir_d;
      phasestep_q    <= phasestep_d;
      sys_reset_n_q  <= sys_reset_n_d;
      locked_q       <= locked_d;
      relock_count_q <= relock_count_d;
      ph_done_q      <= ph_done_d;
      ph_abort_q     <= ph_abort_d;
    end
  end

  assign pll_rst          = pll_rst_q;
  assign pll_phasesel     = phasesel_q;
  assign pll_phasedir     = phasedir_q;
  assign pll_phasestep    = phasestep_q;
  assign pll_phaseloadreg = 1'b0;
  assign pll_stdby        = 1'b0;
  assign sys_reset_n      = sys_reset_n_q;
  assign locked           = locked_q;
  assign relock_count     = relock_count_q;
  assign ph_ready         = (state_q == RUN);
  assign ph_done          = ph_done_q;
  assign ph_abort         = ph_abort_q;

endmodule

// File: tb/tb_ecp5_pll_manager.sv
// Self-checking bench for ecp5_pll_manager: cycle model plus directed scenarios.
module tb_ecp5_pll_manager;

  localparam int unsigned RST  = 4;
  localparam int unsigned STB  = 8;
  localparam int unsigned TMO  = 32;
  localparam int unsigned SETP = 2;
  localparam int unsigned PUL  = 2;
  localparam int unsigned GAP  = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_lock;
  logic       pll_rst;
  logic [1:0] pll_phasesel;
  logic       pll_phasedir;
  logic       pll_phasestep;
  logic       pll_phaseloadreg;
  logic       pll_stdby;
  logic       sys_reset_n;
  logic       locked;
  logic [7:0] relock_count;
  logic       ph_valid;
  logic       ph_ready;
  logic [1:0] ph_sel;
  logic       ph_dir;
  logic [7:0] ph_steps;
  logic       ph_done;
  logic       ph_abort;

  ecp5_pll_manager #(
    .RST_CYCLES   (RST),
    .LOCK_STABLE  (STB),
    .LOCK_TIMEOUT (TMO),
    .SETUP_CYCLES (SETP),
    .STEP_PULSE   (PUL),
    .STEP_GAP     (GAP),
    .STEP_W       (8)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .pll_lock         (pll_lock),
    .pll_rst          (pll_rst),
    .pll_phasesel     (pll_phasesel),
    .pll_phasedir     (pll_phasedir),
    .pll_phasestep    (pll_phasestep),
    .pll_phaseloadreg (pll_phaseloadreg),
    .pll_stdby        (pll_stdby),
    .sys_reset_n      (sys_reset_n),
    .locked           (locked),
    .relock_count     (relock_count),
    .ph_valid         (ph_valid),
    .ph_ready         (ph_ready),
    .ph_sel           (ph_sel),
    .ph_dir           (ph_dir),
    .ph_steps         (ph_steps),
    .ph_done          (ph_done),
    .ph_abort         (ph_abort)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: lifecycle as mode + cycle count; a phase request becomes a queue of PHASESTEP levels.
  int          m_mode = 0;   // 0 pll held in reset, 1 waiting for lock, 2 lock settling, 3 operational
  int unsigned m_cnt  = 0;
  bit          s1 = 0, s2 = 0;
  bit          e_rst = 1, e_sysn = 0, e_locked = 0, e_step = 0, e_dir = 0;
  bit          e_done = 0, e_abort = 0, busy = 0;
  bit   [1:0]  e_sel = 0;
  int unsigned e_relock = 0;
  bit          wave[$];

  function automatic void m_relock();
    m_mode   = 0;
    m_cnt    = 0;
    e_rst    = 1;
    e_sysn   = 0;
    e_locked = 0;
    e_step   = 0;
    busy     = 0;
    wave.delete();
    if (e_relock < 255) e_relock++;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = 0; m_cnt = 0; s1 = 0; s2 = 0;
      e_rst = 1; e_sysn = 0; e_locked = 0; e_step = 0; e_dir = 0;
      e_done = 0; e_abort = 0; busy = 0; e_sel = 0; e_relock = 0;
      wave.delete();
    end else begin
      bit ls;
      ls = s2; s2 = s1; s1 = pll_lock;
      e_done = 0; e_abort = 0;
      case (m_mode)
        0: begin
          m_cnt++;
          if (m_cnt == RST) begin m_mode = 1; m_cnt = 0; e_rst = 0; end
        end
        1: begin
          if (ls) begin m_mode = 2; m_cnt = 0; end
          else begin m_cnt++; if (m_cnt == TMO) m_relock(); end
        end
        2: begin
          if (!ls) begin m_mode = 1; m_cnt = 0; end
          else begin
            m_cnt++;
            if (m_cnt == STB) begin m_mode = 3; e_sysn = 1; e_locked = 1; end
          end
        end
        default: begin
          if (!ls) begin
            e_abort = busy || ph_valid;
            m_relock();
          end else if (busy) begin
            if (wave.size() == 0) begin busy = 0; e_done = 1; end
            else e_step = wave.pop_front();
          end else if (ph_valid) begin
            if (ph_steps == 0) e_done = 1;
            else begin
              e_sel = ph_sel; e_dir = ph_dir; busy = 1;
              for (int i = 0; i < int'(SETP); i++) wave.push_back(1'b0);
              for (int s = 0; s < int'(ph_steps); s++) begin
                for (int i = 0; i < int'(PUL); i++) wave.push_back(1'b1);
                for (int i = 0; i < int'(GAP); i++) wave.push_back(1'b0);
              end
              e_step = wave.pop_front();
            end
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("pll_rst",       32'(pll_rst),          32'(e_rst));
    chk("sys_reset_n",   32'(sys_reset_n),      32'(e_sysn));
    chk("locked",        32'(locked),           32'(e_locked));
    chk("relock_count",  32'(relock_count),     e_relock);
    chk("pll_phasestep", 32'(pll_phasestep),    32'(e_step));
    chk("pll_phasesel",  32'(pll_phasesel),     32'(e_sel));
    chk("pll_phasedir",  32'(pll_phasedir),     32'(e_dir));
    chk("ph_ready",      32'(ph_ready),         32'((m_mode == 3) && !busy));
    chk("ph_done",       32'(ph_done),          32'(e_done));
    chk("ph_abort",      32'(ph_abort),         32'(e_abort));
    chk("phaseloadreg",  32'(pll_phaseloadreg), 0);
    chk("stdby",         32'(pll_stdby),        0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n, rises, highs, done_at, first_rise, extra;
    bit prev, ready_low, saw_abort, saw_done;
    int unsigned t[$];

    reset_n = 0; pll_lock = 0; ph_valid = 0; ph_sel = 0; ph_dir = 0; ph_steps = 0;
    repeat (3) @(negedge clk);
    chk("reset_pll_rst", 32'(pll_rst), 1);
    chk("reset_sys_reset_n", 32'(sys_reset_n), 0);
    chk("reset_relock", 32'(relock_count), 0);
    chk("reset_ph_ready", 32'(ph_ready), 0);
    reset_n = 1;

    // 1: reset pulse length and lock-to-release delay
    n = 0;
    while (pll_rst && n < 100) begin n++; @(negedge clk); end
    chk("t1_rst_high_cycles", n, 4);
    repeat (9) @(negedge clk);
    pll_lock = 1;
    @(negedge clk);
    n = 0;
    while (!sys_reset_n && n < 200) begin @(negedge clk); n++; end
    chk("t1_release_delay", n, 10);
    chk("t1_relock", 32'(relock_count), 0);
    chk("t1_locked", 32'(locked), 1);

    // 3: three steps on CLKOP, direction 1
    chk("t3_ready_before", 32'(ph_ready), 1);
    ph_valid = 1; ph_sel = 2'b11; ph_dir = 1; ph_steps = 3;
    n = 0; rises = 0; highs = 0; done_at = 0; first_rise = 0; prev = 0; ready_low = 1;
    while (done_at == 0 && n < 100) begin
      @(negedge clk); n++;
      if (n == 1) begin
        ph_valid = 0;
        chk("t3_sel_setup", 32'(pll_phasesel), 3);
        chk("t3_dir_setup", 32'(pll_phasedir), 1);
      end
      if (pll_phasestep && !prev) begin rises++; if (first_rise == 0) first_rise = n; end
      if (pll_phasestep) highs++;
      prev = pll_phasestep;
      if (ph_done) done_at = n;
      else if (ph_ready) ready_low = 0;
    end
    chk("t3_first_step_cycle", first_rise, 3);
    chk("t3_step_pulses", rises, 3);
    chk("t3_step_high_cycles", highs, 6);
    chk("t3_done_cycle", done_at, 15);
    chk("t3_ready_low", 32'(ready_low), 1);

    // 4: zero-step request completes immediately without touching the PLL
    ph_valid = 1; ph_sel = 2'b10; ph_dir = 0; ph_steps = 0;
    @(negedge clk);
    ph_valid = 0;
    chk("t4_done", 32'(ph_done), 1);
    chk("t4_ready", 32'(ph_ready), 1);
    chk("t4_step", 32'(pll_phasestep), 0);
    chk("t4_sel_held", 32'(pll_phasesel), 3);
    @(negedge clk);
    chk("t4_done_one_cycle", 32'(ph_done), 0);

    // 5: lock lost during the second step pulse
    ph_valid = 1; ph_sel = 2'b01; ph_dir = 0; ph_steps = 4;
    n = 0; rises = 0; prev = 0;
    while (rises < 2 && n < 100) begin
      @(negedge clk); n++;
      if (n == 1) ph_valid = 0;
      if (pll_phasestep && !prev) rises++;
      prev = pll_phasestep;
    end
    chk("t5_second_pulse_cycle", n, 7);
    pll_lock = 0;
    saw_abort = 0;
    repeat (3) begin
      @(negedge clk);
      if (ph_abort) saw_abort = 1;
    end
    chk("t5_abort", 32'(saw_abort), 1);
    chk("t5_step_low", 32'(pll_phasestep), 0);
    chk("t5_sys_reset_n", 32'(sys_reset_n), 0);
    chk("t5_pll_rst", 32'(pll_rst), 1);
    chk("t5_relock", 32'(relock_count), 1);
    saw_done = 0;
    repeat (20) begin @(negedge clk); if (ph_done) saw_done = 1; end
    chk("t5_no_done", 32'(saw_done), 0);
    pll_lock = 1;
    n = 0;
    while (!sys_reset_n && n < 200) begin @(negedge clk); n++; end
    chk("t5_relocked", 32'(n < 200), 1);
    chk("t5_relock_after", 32'(relock_count), 1);

    // 6: short lock glitch while settling restarts the stable window
    pll_lock = 0;
    n = 0;
    while (!pll_rst && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (pll_rst && n < 20) begin @(negedge clk); n++; end
    chk("t6_relock", 32'(relock_count), 2);
    pll_lock = 1;
    repeat (5) @(negedge clk);
    pll_lock = 0;
    repeat (3) @(negedge clk);
    pll_lock = 1;
    @(negedge clk);
    n = 0;
    while (!sys_reset_n && n < 200) begin @(negedge clk); n++; end
    chk("t6_release_delay", n, 10);

    // 2: no lock at all; periodic re-pulse and counter saturation
    pll_lock = 0;
    n = 0; prev = pll_rst;
    while (relock_count != 8'd255 && n < 12000) begin
      @(negedge clk); n++;
      if (pll_rst && !prev) t.push_back(n);
      prev = pll_rst;
    end
    chk("t2_reached_255", 32'(relock_count), 255);
    chk("t2_period_a", t[1] - t[0], 36);
    chk("t2_period_b", t[2] - t[1], 36);
    extra = 0;
    repeat (100) begin
      @(negedge clk);
      if (pll_rst && !prev) extra++;
      prev = pll_rst;
    end
    chk("t2_still_pulsing", 32'(extra >= 2), 1);
    chk("t2_saturated", 32'(relock_count), 255);

    // asynchronous reset mid-operation
    @(posedge clk);
    #2 reset_n = 0;
    #1;
    chk("areset_pll_rst", 32'(pll_rst), 1);
    chk("areset_sys_reset_n", 32'(sys_reset_n), 0);
    chk("areset_relock", 32'(relock_count), 0);
    chk("areset_locked", 32'(locked), 0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
